wb_rr_arbiter: RTL and testbench
================================

WB_RR_ARBITER -- requirements
Module: wb_rr_arbiter

Interface
REQ-001 SHALL have parameter NUM_MASTERS, default 2, number of Wishbone masters sharing one slave port (range 2..8).
REQ-002 SHALL have parameter AW, default 32, address width.
REQ-003 SHALL have parameter DW, default 32, data width; sel width is DW/8.
REQ-004 SHALL have parameter TIMEOUT, default 255, bus-watchdog limit in cycles; 0 disables the watchdog.
REQ-005 SHALL have port wb_clk_i  in  1  single clock; all logic on its rising edge.
REQ-006 SHALL have port wb_rst_ni  in  1  reset, asynchronous assert, active-low.
REQ-007 SHALL have ports m_adr_i/m_dat_i/m_sel_i  in  NUM_MASTERS*AW / NUM_MASTERS*DW / NUM_MASTERS*DW/8  master requests, flattened, master k at slice k.
REQ-008 SHALL have ports m_we_i, m_cyc_i, m_stb_i  in  NUM_MASTERS each  per-master control.
REQ-009 SHALL have ports m_dat_o  out  DW (shared read data); m_ack_o, m_err_o  out  NUM_MASTERS each.
REQ-010 SHALL have ports s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o  out  AW/DW/DW/8/1/1/1  slave side.
REQ-011 SHALL have ports s_dat_i  in  DW; s_ack_i, s_err_i  in  1 each.
REQ-012 SHALL have port grant_o  out  NUM_MASTERS  registered one-hot owner, all zero when idle.
REQ-013 SHALL have port timeout_o  out  1  one-cycle pulse when the watchdog fires.

Function
REQ-014 SHALL implement a two-state FSM: IDLE, BUSY.
REQ-015 In IDLE with any m_cyc_i set, SHALL select the first requester at or after rotating pointer ptr (modulo NUM_MASTERS), register it in grant_o, and enter BUSY next cycle (one-cycle grant latency).
REQ-016 In BUSY, s_adr_o/s_dat_o/s_sel_o/s_we_o/s_cyc_o/s_stb_o SHALL combinationally mirror the owner's inputs; in IDLE, s_cyc_o and s_stb_o SHALL be 0.
REQ-017 m_dat_o SHALL equal s_dat_i; s_ack_i/s_err_i SHALL route only to the owner's m_ack_o/m_err_o; non-owners see 0.
REQ-018 Ownership SHALL persist while the owner's m_cyc_i stays high, including multi-beat and idle-stb cycles; other requests are ignored.
REQ-019 When the owner drops m_cyc_i, the arbiter SHALL return to IDLE, set ptr to owner+1 (wrap to 0 after NUM_MASTERS-1), and clear grant_o; the next grant occurs one cycle later (one dead cycle between owners).
REQ-020 Watchdog counter (width clog2(TIMEOUT+1)) SHALL increment on each BUSY cycle with s_stb_o=1 and s_ack_i=s_err_i=0, and clear on ack, err, or leaving BUSY.
REQ-021 When the counter reaches TIMEOUT, the arbiter SHALL assert m_err_o of the owner and timeout_o for exactly one cycle, force s_cyc_o/s_stb_o low that cycle, advance ptr as in REQ-019, and return to IDLE.
REQ-022 If s_ack_i and the timeout condition coincide, ack SHALL win and no error is generated.
REQ-023 With TIMEOUT=0 the counter SHALL not be instantiated and timeout_o SHALL be constant 0.
REQ-024 A master with m_cyc_i high and m_stb_i low in IDLE SHALL still be granted; stb does not affect arbitration.

Reset
REQ-025 On wb_rst_ni low, asynchronously: state=IDLE, ptr=0, grant_o=0, counter=0, timeout_o=0; hence s_cyc_o=s_stb_o=0, all m_ack_o/m_err_o=0.
REQ-026 Reset asserted mid-transfer SHALL abort it without issuing ack or err; after release, arbitration restarts from master 0.

Structure
REQ-027 Shared package SHALL hold the FSM state encoding and a clog2 function; no other typedefs.
REQ-028 A single sub-module wb_rr_pick (combinational rotating-priority one-hot selector, NUM_MASTERS wide) is natural; everything else stays in wb_rr_arbiter.

Verification
REQ-029 NUM_MASTERS=2, both raise cyc in cycle 0 after reset -> grant_o=01 at cycle 1; on m0 cyc drop, grant_o=00 for one cycle, then 10.
REQ-030 NUM_MASTERS=4, masters 0..3 request continuously, each holds 3 beats -> grant order 0,1,2,3,0; no master starves.
REQ-031 TIMEOUT=4, owner stb high, slave never acks -> m_err_o of owner and timeout_o high on the 4th waiting cycle, s_cyc_o low that cycle, IDLE next.
REQ-032 TIMEOUT=4, s_ack_i arrives on the 4th waiting cycle -> ack delivered, no err, timeout_o=0.
REQ-033 Owner m1 mid-transfer (adr 0x0000_1000), wb_rst_ni pulsed low -> s_cyc_o=0 immediately, no ack/err, next grant goes to m0 if requesting.
REQ-034 Non-owner m1 with cyc/stb high while m0 reads 0xDEADBEEF -> m_ack_o[1]=0 and m_err_o[1]=0 throughout; m0 receives ack with m_dat_o=0xDEADBEEF.

Source files
------------

// File: rtl/wb_rr_arbiter_pkg.sv
// wb_rr_arbiter_pkg: FSM state encoding and clog2 helper shared by the arbiter files
package wb_rr_arbiter_pkg;
  typedef enum logic {IDLE, BUSY} state_t;
  function automatic int clog2(input int v);
    int r = 0;
    while ((1 << r) < v) r = r + 1;
    return r;
  endfunction
endpackage

// File: rtl/wb_rr_pick.sv
// wb_rr_pick: one-hot select of the first requester at or after ptr, wrapping modulo N
module wb_rr_pick
  import wb_rr_arbiter_pkg::*;
#(
  parameter int N  = 2,
  parameter int PW = clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt
);
  // scan from the farthest offset down so the nearest requester overwrites last
  always_comb begin
    gnt = '0;
    for (int i = N - 1; i >= 0; i--)
      if (req[(int'(ptr) + i) % N]) gnt = N'(1) << ((int'(ptr) + i) % N);
  end
endmodule

// File: rtl/wb_rr_arbiter.sv
// wb_rr_arbiter: round-robin Wishbone arbiter, NUM_MASTERS masters onto one slave, with bus watchdog
module wb_rr_arbiter
  import wb_rr_arbiter_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int TIMEOUT     = 255
) (
  input  logic                        wb_clk_i,
  input  logic                        wb_rst_ni,
  input  logic [NUM_MASTERS*AW-1:0]   m_adr_i,
  input  logic [NUM_MASTERS*DW-1:0]   m_dat_i,
  input  logic [NUM_MASTERS*DW/8-1:0] m_sel_i,
  input  logic [NUM_MASTERS-1:0]      m_we_i,
  input  logic [NUM_MASTERS-1:0]      m_cyc_i,
  input  logic [NUM_MASTERS-1:0]      m_stb_i,
  output logic [DW-1:0]               m_dat_o,
  output logic [NUM_MASTERS-1:0]      m_ack_o,
  output logic [NUM_MASTERS-1:0]      m_err_o,
  output logic [AW-1:0]               s_adr_o,
  output logic [DW-1:0]               s_dat_o,
  output logic [DW/8-1:0]             s_sel_o,
  output logic                        s_we_o,
  output logic                        s_cyc_o,
  output logic                        s_stb_o,
  input  logic [DW-1:0]               s_dat_i,
  input  logic                        s_ack_i,
  input  logic                        s_err_i,
  output logic [NUM_MASTERS-1:0]      grant_o,
  output logic                        timeout_o
);
  localparam int N  = NUM_MASTERS;
  localparam int PW = clog2(N);
  localparam int SW = DW / 8;
  state_t state, state_d;
  logic [N-1:0] pick, grant_d;
  logic [PW-1:0] ptr, ptr_d, oidx;
  logic busy, own_cyc, own_stb, fire;
  wb_rr_pick #(.N(N), .PW(PW)) u_pick (.req(m_cyc_i), .ptr(ptr), .gnt(pick));
  always_comb begin
    oidx = '0;
    for (int i = 0; i < N; i++) if (grant_o[i]) oidx = PW'(i);
  end
  assign busy      = state == BUSY;
  assign own_cyc   = m_cyc_i[oidx];
  assign own_stb   = m_stb_i[oidx];
  assign s_adr_o   = m_adr_i[oidx*AW +: AW];
  assign s_dat_o   = m_dat_i[oidx*DW +: DW];
  assign s_sel_o   = m_sel_i[oidx*SW +: SW];
  assign s_we_o    = m_we_i[oidx];
  assign s_cyc_o   = busy & own_cyc & ~fire;
  assign s_stb_o   = busy & own_stb & ~fire;
  assign m_dat_o   = s_dat_i;
  assign m_ack_o   = (busy && s_ack_i) ? grant_o : '0;
  assign m_err_o   = (busy && (s_err_i || fire)) ? grant_o : '0;
  assign timeout_o = fire;
  if (TIMEOUT > 0) begin : g_wd
    localparam int CW = clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt;
    logic wait_c;
    // fire on the TIMEOUT-th unanswered strobe; a same-cycle ack or err masks it
    assign wait_c = busy & own_cyc & own_stb & ~s_ack_i & ~s_err_i;
    assign fire   = wait_c & (cnt == CW'(TIMEOUT - 1));
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni)
      if (!wb_rst_ni) cnt <= '0;
      else cnt <= (wait_c && !fire) ? cnt + 1'b1 : '0;
  end else begin : g_nowd
    assign fire = 1'b0;
  end
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni)
    if (!wb_rst_ni) begin
      state   <= IDLE;
      grant_o <= '0;
      ptr     <= '0;
    end else begin
      state   <= state_d;
      grant_o <= grant_d;
      ptr     <= ptr_d;
    end
  always_comb begin
    state_d = state;
    grant_d = grant_o;
    ptr_d   = ptr;
    if (!busy) begin
      state_d = |m_cyc_i ? BUSY : IDLE;
      grant_d = |m_cyc_i ? pick : '0;
    end else if (!own_cyc || fire) begin
      state_d = IDLE;
      grant_d = '0;
      ptr_d   = (oidx == PW'(N - 1)) ? '0 : oidx + 1'b1;
    end
  end
endmodule

// File: tb/tb_wb_rr_arbiter.sv
// tb_wb_rr_arbiter: directed checks of a 2-master (no watchdog) and a 4-master (TIMEOUT=4) arbiter
module tb_wb_rr_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  logic [63:0] a_adr, a_dat;
  logic [7:0]  a_sel;
  logic [1:0]  a_we, a_cyc, a_stb, a_ack, a_err, a_grant;
  logic [31:0] a_mdat, a_sadr, a_sdat, a_sdi;
  logic [3:0]  a_ssel;
  logic        a_swe, a_scyc, a_sstb, a_sack, a_serr, a_to;
  logic [127:0] b_adr, b_dat;
  logic [15:0] b_sel;
  logic [3:0]  b_we, b_cyc, b_stb, b_ack, b_err, b_grant, exp;
  logic [31:0] b_mdat, b_sadr, b_sdat, b_sdi;
  logic [3:0]  b_ssel;
  logic        b_swe, b_scyc, b_sstb, b_sack, b_serr, b_to, seen;
  wb_rr_arbiter #(.NUM_MASTERS(2), .AW(32), .DW(32), .TIMEOUT(0)) u2 (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .m_adr_i(a_adr), .m_dat_i(a_dat), .m_sel_i(a_sel), .m_we_i(a_we), .m_cyc_i(a_cyc), .m_stb_i(a_stb),
    .m_dat_o(a_mdat), .m_ack_o(a_ack), .m_err_o(a_err),
    .s_adr_o(a_sadr), .s_dat_o(a_sdat), .s_sel_o(a_ssel), .s_we_o(a_swe), .s_cyc_o(a_scyc), .s_stb_o(a_sstb),
    .s_dat_i(a_sdi), .s_ack_i(a_sack), .s_err_i(a_serr), .grant_o(a_grant), .timeout_o(a_to)
  );
  wb_rr_arbiter #(.NUM_MASTERS(4), .AW(32), .DW(32), .TIMEOUT(4)) u4 (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .m_adr_i(b_adr), .m_dat_i(b_dat), .m_sel_i(b_sel), .m_we_i(b_we), .m_cyc_i(b_cyc), .m_stb_i(b_stb),
    .m_dat_o(b_mdat), .m_ack_o(b_ack), .m_err_o(b_err),
    .s_adr_o(b_sadr), .s_dat_o(b_sdat), .s_sel_o(b_ssel), .s_we_o(b_swe), .s_cyc_o(b_scyc), .s_stb_o(b_sstb),
    .s_dat_i(b_sdi), .s_ack_i(b_sack), .s_err_i(b_serr), .grant_o(b_grant), .timeout_o(b_to)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst_n = 1'b0;
    a_adr = {32'h0000_0200, 32'h0000_0100}; a_dat = '0; a_sel = '1; a_we = '0;
    a_cyc = '0; a_stb = '0; a_sdi = '0; a_sack = 1'b0; a_serr = 1'b0;
    b_adr = {32'h0000_3000, 32'h0000_2000, 32'h0000_1000, 32'h0000_0400}; b_dat = '0; b_sel = '1; b_we = '0;
    b_cyc = '0; b_stb = '0; b_sdi = '0; b_sack = 1'b0; b_serr = 1'b0;
    #12;
    chk("rst_a_grant", a_grant, 0);
    chk("rst_a_scyc", {a_scyc, a_sstb}, 0);
    chk("rst_b_grant", b_grant, 0);
    chk("rst_b_scyc", {b_scyc, b_sstb}, 0);
    chk("rst_b_to", b_to, 0);
    chk("rst_b_ackerr", {b_ack, b_err}, 0);
    tick;
    rst_n = 1'b1;
    tick;
    a_cyc = 2'b11; a_stb = 2'b11;
    tick;
    chk("two_grant0", a_grant, 2'b01);
    chk("two_scyc", a_scyc, 1);
    chk("two_sadr", a_sadr, 32'h100);
    a_sdi = 32'hDEAD_BEEF; a_sack = 1'b1;
    #1;
    chk("nonowner_ack", a_ack, 2'b01);
    chk("nonowner_err", a_err, 2'b00);
    chk("read_data", a_mdat, 32'hDEAD_BEEF);
    tick;
    a_sack = 1'b0; a_cyc = 2'b10;
    tick;
    chk("two_dead", a_grant, 2'b00);
    chk("two_dead_scyc", a_scyc, 0);
    tick;
    chk("two_grant1", a_grant, 2'b10);
    chk("two_sadr1", a_sadr, 32'h200);
    seen = 1'b0;
    repeat (10) begin
      tick;
      seen |= a_to;
    end
    chk("no_watchdog", seen, 0);
    chk("hold_grant1", a_grant, 2'b10);
    a_sack = 1'b1;
    #1;
    chk("ack_m1", a_ack, 2'b10);
    tick;
    a_sack = 1'b0; a_cyc = '0; a_stb = '0;
    tick;
    b_cyc = 4'hf; b_stb = 4'hf;
    for (int i = 0; i < 5; i++) begin
      for (int k = 0; k < 8 && b_grant == 0; k++) tick;
      exp = 4'b0001 << (i % 4);
      chk("rr_grant", b_grant, exp);
      b_sack = 1'b1;
      #1;
      chk("rr_ack", b_ack, exp);
      repeat (3) tick;
      b_sack = 1'b0; b_cyc = b_cyc & ~exp;
      tick;
      chk("rr_dead", b_grant, 0);
      b_cyc = (i == 4) ? 4'h0 : 4'hf;
    end
    b_stb = '0;
    tick;
    b_cyc = 4'b0100; b_stb = 4'b0100;
    tick;
    chk("to_grant", b_grant, 4'b0100);
    tick;
    tick;
    chk("to_early", {b_to, b_err}, 0);
    chk("to_early_scyc", b_scyc, 1);
    tick;
    chk("to_pulse", b_to, 1);
    chk("to_err", b_err, 4'b0100);
    chk("to_scyc", {b_scyc, b_sstb}, 0);
    tick;
    chk("to_idle", b_grant, 0);
    chk("to_once", b_to, 0);
    b_cyc = '0; b_stb = '0;
    tick;
    b_cyc = 4'b0001; b_stb = 4'b0001; b_sdi = 32'h1234_5678;
    tick;
    chk("ackwin_grant", b_grant, 4'b0001);
    repeat (3) tick;
    b_sack = 1'b1;
    #1;
    chk("ackwin_ack", b_ack, 4'b0001);
    chk("ackwin_noerr", {b_to, b_err}, 0);
    chk("ackwin_scyc", b_scyc, 1);
    tick;
    b_sack = 1'b0; b_cyc = '0; b_stb = '0;
    tick;
    b_cyc = 4'b0011; b_stb = 4'b0011;
    tick;
    chk("rst_mid_grant", b_grant, 4'b0010);
    chk("rst_mid_sadr", b_sadr, 32'h1000);
    rst_n = 1'b0; b_sack = 1'b1;
    #1;
    chk("rst_mid_scyc", b_scyc, 0);
    chk("rst_mid_ackerr", {b_ack, b_err}, 0);
    chk("rst_mid_clr", b_grant, 0);
    tick;
    rst_n = 1'b1; b_sack = 1'b0;
    tick;
    chk("rst_restart", b_grant, 4'b0001);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
